// File: rtl/mtimer_mmio.sv
// Memory-mapped machine timer: 64-bit mtime counter plus 64-bit mtimecmp,
// served as four word registers on the core's data port. mtip_o is a
// registered level that stays high while mtime >= mtimecmp.
module mtimer_mmio #(
    parameter int unsigned TICK_DIV = 1,
    parameter logic [31:0] BASE_LO  = 32'h0000_8004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        mtip_o
);

    // Prescaler needs at least one bit even when it never counts (TICK_DIV=1).
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    logic [63:0]   mtime, mtime_next;
    logic [63:0]   mtimecmp, mtimecmp_next;
    logic [PW-1:0] prescaler, prescaler_next;
    logic          snap_valid, snap_valid_next;
    logic [31:0]   hi_snap, hi_snap_next;
    logic [31:0]   rdata_next;
    logic          tick;

    logic aligned;
    logic sel_mtime_lo, sel_mtime_hi, sel_cmp_lo, sel_cmp_hi, hit;
    logic wr, rd;

    // Address decode: exact word match on one of the four registers.
    always_comb begin
        aligned      = (addr_i[1:0] == 2'b00);
        sel_mtime_lo = aligned && (addr_i == BASE_LO);
        sel_mtime_hi = aligned && (addr_i == BASE_LO + 32'd4);
        sel_cmp_lo   = aligned && (addr_i == BASE_LO + 32'd8);
        sel_cmp_hi   = aligned && (addr_i == BASE_LO + 32'd12);
        hit          = sel_mtime_lo | sel_mtime_hi | sel_cmp_lo | sel_cmp_hi;
        wr           = req_i && we_i && hit;
        rd           = req_i && !we_i && hit;
    end

    assign tick = (prescaler == PRE_MAX);

    // Next-state for the counter, prescaler and compare register.
    // A store to either mtime half wins over the tick for the whole counter,
    // so the untouched half is neither incremented nor carried into.
    always_comb begin
        mtime_next     = tick ? mtime + 64'd1 : mtime;
        prescaler_next = tick ? '0 : prescaler + PW'(1);
        mtimecmp_next  = mtimecmp;
        if (wr && sel_mtime_lo) begin
            mtime_next     = {mtime[63:32], wdata_i};
            prescaler_next = '0;
        end else if (wr && sel_mtime_hi) begin
            mtime_next     = {wdata_i, mtime[31:0]};
            prescaler_next = '0;
        end
        if (wr && sel_cmp_lo) begin
            mtimecmp_next = {mtimecmp[63:32], wdata_i};
        end else if (wr && sel_cmp_hi) begin
            mtimecmp_next = {wdata_i, mtimecmp[31:0]};
        end
    end

    // High-word snapshot: a low read freezes the matching high half so that a
    // following high read sees a consistent 64-bit value across a carry.
    always_comb begin
        hi_snap_next    = hi_snap;
        snap_valid_next = snap_valid;
        if (rd && sel_mtime_lo) begin
            hi_snap_next    = mtime[63:32];
            snap_valid_next = 1'b1;
        end else if (rd && sel_mtime_hi) begin
            snap_valid_next = 1'b0;
        end else if (wr && (sel_mtime_lo || sel_mtime_hi)) begin
            snap_valid_next = 1'b0;
        end
    end

    // Load data is taken from the pre-write/pre-tick state of the request cycle.
    always_comb begin
        rdata_next = 32'd0;
        if (rd) begin
            if (sel_mtime_lo) begin
                rdata_next = mtime[31:0];
            end else if (sel_mtime_hi) begin
                rdata_next = snap_valid ? hi_snap : mtime[63:32];
            end else if (sel_cmp_lo) begin
                rdata_next = mtimecmp[31:0];
            end else begin
                rdata_next = mtimecmp[63:32];
            end
        end
    end

    // Timer state; reset leaves mtimecmp at all-ones so mtip stays low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mtime      <= 64'd0;
            mtimecmp   <= 64'hFFFF_FFFF_FFFF_FFFF;
            prescaler  <= '0;
            snap_valid <= 1'b0;
            hi_snap    <= 32'd0;
            mtip_o     <= 1'b0;
        end else begin
            mtime      <= mtime_next;
            mtimecmp   <= mtimecmp_next;
            prescaler  <= prescaler_next;
            snap_valid <= snap_valid_next;
            hi_snap    <= hi_snap_next;
            mtip_o     <= (mtime_next >= mtimecmp_next);
        end
    end

    // Single-cycle response: one strobe per request, no backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid_o <= 1'b0;
            rdata_o  <= 32'd0;
            err_o    <= 1'b0;
        end else begin
            rvalid_o <= req_i;
            rdata_o  <= rdata_next;
            err_o    <= req_i && !hit;
        end
    end

endmodule

// File: tb/tb_mtimer_mmio.sv
// Bench for mtimer_mmio: two instances (TICK_DIV=1 and 4) against a model
// that derives mtime arithmetically from the last load point.
module tb_mtimer_mmio;

    localparam logic [31:0] B = 32'h0000_8004;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req[2], we[2], rvalid[2], err[2], mtip[2];
    logic [31:0] addr[2], wdata[2], rdata[2];

    always #5 clk = ~clk;

    mtimer_mmio #(.TICK_DIV(1), .BASE_LO(B)) u0 (
        .clk(clk), .rst(rst), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
        .wdata_i(wdata[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]),
        .err_o(err[0]), .mtip_o(mtip[0]));

    mtimer_mmio #(.TICK_DIV(4), .BASE_LO(B)) u1 (
        .clk(clk), .rst(rst), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
        .wdata_i(wdata[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]),
        .err_o(err[1]), .mtip_o(mtip[1]));

    longint unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: mtime(c) = base + (c - t0) / TICK_DIV, t0 = first cycle after a load/reset.
    logic [63:0]     m_base[2];
    logic [63:0]     m_cmp[2];
    longint unsigned m_t0[2];
    longint unsigned td[2] = '{1, 4};
    logic            m_sv[2];
    logic [31:0]     m_snap[2];

    int checks   = 0;
    int failures = 0;
    logic chk_en = 1'b0;

    function automatic logic [63:0] mt(input int i, input longint unsigned c);
        return m_base[i] + ((c - m_t0[i]) / td[i]);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Interrupt level must equal the unsigned compare of the current values.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++)
                chk($sformatf("mtip%0d", i), 64'(mtip[i]), 64'(mt(i, cyc) >= m_cmp[i]));
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_base[i] = 64'd0;
            m_cmp[i]  = '1;
            m_t0[i]   = cyc;
            m_sv[i]   = 1'b0;
            m_snap[i] = 32'd0;
        end
    endtask

    // One access starting in the current cycle; checks the response next cycle.
    task automatic acc(input int i, input logic w, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd);
        longint unsigned c;
        logic [63:0] cur;
        logic [31:0] er;
        logic        hit;
        c   = cyc;
        cur = mt(i, c);
        req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
        @(posedge clk); #1;
        req[i] = 1'b0; we[i] = 1'b0;
        hit = (a == B) || (a == B + 4) || (a == B + 8) || (a == B + 12);
        er  = 32'd0;
        if (hit && !w) begin
            if (a == B) begin
                er = cur[31:0]; m_snap[i] = cur[63:32]; m_sv[i] = 1'b1;
            end else if (a == B + 4) begin
                er = m_sv[i] ? m_snap[i] : cur[63:32]; m_sv[i] = 1'b0;
            end else if (a == B + 8) begin
                er = m_cmp[i][31:0];
            end else begin
                er = m_cmp[i][63:32];
            end
        end else if (hit && w) begin
            if (a == B) begin
                m_base[i] = {cur[63:32], d}; m_t0[i] = c + 1; m_sv[i] = 1'b0;
            end else if (a == B + 4) begin
                m_base[i] = {d, cur[31:0]}; m_t0[i] = c + 1; m_sv[i] = 1'b0;
            end else if (a == B + 8) begin
                m_cmp[i][31:0] = d;
            end else begin
                m_cmp[i][63:32] = d;
            end
        end
        chk($sformatf("rvalid%0d@%h", i, a), 64'(rvalid[i]), 64'd1);
        chk($sformatf("err%0d@%h", i, a), 64'(err[i]), 64'(!hit));
        chk($sformatf("rdata%0d@%h", i, a), 64'(rdata[i]), 64'(er));
        rd = rdata[i];
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            chk("idle_rvalid0", 64'(rvalid[0]), 64'd0);
            chk("idle_rvalid1", 64'(rvalid[1]), 64'd0);
        end
    endtask

    task automatic release_rst();
        @(posedge clk); #3;
        rst = 1'b0;
        model_reset();
        chk_en = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] rd, a;
        longint unsigned w, r;
        int n;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
        end

        // Reset state
        #2;
        for (int i = 0; i < 2; i++) begin
            chk("rst_rvalid", 64'(rvalid[i]), 64'd0);
            chk("rst_rdata", 64'(rdata[i]), 64'd0);
            chk("rst_err", 64'(err[i]), 64'd0);
            chk("rst_mtip", 64'(mtip[i]), 64'd0);
        end
        repeat (2) @(posedge clk);
        release_rst();

        // T1: LOW read at cycle 10 after reset release
        r = m_t0[0];
        while (cyc < r + 10) begin @(posedge clk); #1; end
        acc(0, 0, B, 0, rd);
        chk("t1_const", 64'(rd), 64'd10);
        acc(1, 0, B, 0, rd);

        // T2: carry from low to high word
        acc(0, 1, B + 4, 32'h0, rd);
        acc(0, 1, B, 32'hFFFF_FFFE, rd);
        idle(3);
        acc(0, 0, B, 0, rd);
        chk("t2_lo", 64'(rd), 64'h1);
        acc(0, 0, B + 4, 0, rd);
        chk("t2_hi", 64'(rd), 64'h1);

        // T3: compare match raises mtip, raising mtimecmp clears it
        acc(0, 1, B + 4, 32'h0, rd);
        acc(0, 1, B, 32'h0, rd);
        w = m_t0[0];
        acc(0, 1, B + 12, 32'h0, rd);
        acc(0, 1, B + 8, 32'h20, rd);
        n = 0;
        while (!mtip[0] && n < 100) begin @(posedge clk); #1; n++; end
        chk("t3_rise_cycle", 64'(cyc), 64'(w + 32'h20));
        acc(0, 1, B + 8, 32'hFFFF_FFFF, rd);
        chk("t3_fall", 64'(mtip[0]), 64'd0);

        // T4: store on a tick cycle drops the increment and restarts the prescaler
        n = 0;
        while (((cyc - m_t0[1]) % 4) != 3 && n < 8) begin @(posedge clk); #1; n++; end
        acc(1, 1, B, 32'h1234_5678, rd);
        acc(1, 0, B, 0, rd);
        chk("t4_noinc", 64'(rd), 64'h1234_5678);
        idle(2);
        acc(1, 0, B, 0, rd);
        chk("t4_hold", 64'(rd), 64'h1234_5678);
        acc(1, 0, B, 0, rd);
        chk("t4_inc", 64'(rd), 64'h1234_5679);

        // T5: snapshot across a carry
        acc(0, 1, B + 4, 32'h0, rd);
        acc(0, 1, B, 32'hFFFF_FFFF, rd);
        acc(0, 0, B, 0, rd);
        chk("t5_lo", 64'(rd), 64'hFFFF_FFFF);
        acc(0, 0, B + 4, 0, rd);
        chk("t5_snap", 64'(rd), 64'h0);
        acc(0, 0, B + 4, 0, rd);
        chk("t5_live", 64'(rd), 64'h1);

        // 64-bit wrap to zero
        acc(0, 1, B + 4, 32'hFFFF_FFFF, rd);
        acc(0, 1, B, 32'hFFFF_FFFD, rd);
        idle(3);
        acc(0, 0, B, 0, rd);
        acc(0, 0, B + 4, 0, rd);

        // T6: unmapped and misaligned accesses
        acc(0, 0, 32'h0000_8014, 0, rd);
        acc(0, 0, 32'h0000_8006, 0, rd);
        acc(0, 1, 32'h0000_8006, 32'hDEAD_BEEF, rd);
        acc(0, 0, B, 0, rd);

        // T6: reset between request and response
        req[0] = 1'b1; we[0] = 1'b0; addr[0] = B;
        #3;
        chk_en = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        req[0] = 1'b0;
        chk("t6_rvalid", 64'(rvalid[0]), 64'd0);
        chk("t6_mtip", 64'(mtip[0]), 64'd0);
        release_rst();
        acc(0, 0, B, 0, rd);
        acc(0, 0, B + 4, 0, rd);
        chk("t6_hi_zero", 64'(rd), 64'd0);

        // Randomized accesses on both instances
        for (int k = 0; k < 200; k++) begin
            int i, sel;
            i   = int'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 9));
            if (sel < 8)       a = B + 32'(4 * (sel % 4));
            else if (sel == 8) a = B + 32'(16 + 4 * $urandom_range(0, 3));
            else               a = B + 32'($urandom_range(1, 3));
            acc(i, 1'($urandom_range(0, 1)), a, $urandom, rd);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end

        idle(2);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
